load_store_unit: RTL and testbench

- Sits directly upstream of the word-wide on-chip memory and drives its port: word address, write data, byte strobes, read/write enables.
- Converts CPU byte/half/word load and store requests into word-lane memory cycles; returns steered and optionally sign-extended load data with a one-pulse acknowledge.
- Compensates for the memory latching on the falling clock edge.

---
 rtl/load_store_unit_pkg.sv | 36 +++
 rtl/load_store_unit_lane_steer.sv | 63 ++++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: width encodings, FSM states,
// wait-state limit and offset/alignment helpers.
package load_store_unit_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    localparam int WAIT_CYCLES_MAX = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    // Halves only honour bit 1, words ignore both low bits.
    function automatic logic [1:0] force_offset(input logic [1:0] width, input logic [1:0] offset);
        if (width == WIDTH_BYTE)
            return offset;
        else if (width == WIDTH_HALF)
            return {offset[1], 1'b0};
        else
            return 2'b00;
    endfunction

    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] offset);
        if (width == WIDTH_BYTE)
            return 1'b0;
        else if (width == WIDTH_HALF)
            return offset[0];
        else
            return offset != 2'b00;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_steer.sv
// lsu_lane_steer: big-endian byte-strobe generation, store-data replication
// and load-data extraction with zero/sign extension. Purely combinational.
module lsu_lane_steer
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  strobes,
    output logic [31:0] store_data,
    output logic [31:0] load_data
);

    function automatic logic [31:0] extend8(input logic [7:0] v, input logic s);
        logic signed [7:0] sv;
        sv = signed'(v);
        return s ? 32'(sv) : 32'(v);
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] v, input logic s);
        logic signed [15:0] sv;
        sv = signed'(v);
        return s ? 32'(sv) : 32'(v);
    endfunction

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        // Offset 0 is the most significant lane.
        case (offset)
            2'd0:    lane8 = rdata_word[31:24];
            2'd1:    lane8 = rdata_word[23:16];
            2'd2:    lane8 = rdata_word[15:8];
            default: lane8 = rdata_word[7:0];
        endcase
        lane16 = offset[1] ? rdata_word[15:0] : rdata_word[31:16];

        strobes    = 4'b1111;
        store_data = wdata;
        load_data  = rdata_word;
        case (width)
            WIDTH_BYTE: begin
                strobes    = 4'b1000 >> offset;
                store_data = {4{wdata[7:0]}};
                load_data  = extend8(lane8, sign_ext);
            end
            WIDTH_HALF: begin
                strobes    = offset[1] ? 4'b0011 : 4'b1100;
                store_data = {2{wdata[15:0]}};
                load_data  = extend16(lane16, sign_ext);
            end
            default: begin
                strobes    = 4'b1111;
                store_data = wdata;
                load_data  = rdata_word;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-wide memory that latches on the falling edge.
// Optional LSU_ALIGN_CHECK_EN rejects misaligned half/word accesses with align_error.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    input  logic        req_write,
    input  logic [1:0]  req_width,
    input  logic        req_signed,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        align_error,
    output logic [29:0] mem_address,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    output logic [3:0]  mem_data_strobes,
    output logic        mem_read,
    output logic        mem_write
);

    localparam int         WAIT_EFF  = (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_EFF);

    lsu_state_t  state;
    logic [3:0]  wait_count;
    logic [1:0]  lat_width;
    logic [1:0]  lat_offset;
    logic        lat_signed;
    logic        lat_write;

    logic [1:0]  req_offset;
    logic        reject;
    logic [1:0]  steer_width;
    logic [1:0]  steer_offset;
    logic        steer_signed;
    logic [3:0]  steer_strobes;
    logic [31:0] steer_store;
    logic [31:0] steer_load;

    assign req_offset = force_offset(req_width, req_address[1:0]);

`ifdef LSU_ALIGN_CHECK_EN
    assign reject = misaligned(req_width, req_address[1:0]);
`else
    assign reject = 1'b0;
`endif

    // In IDLE the steer sees the incoming request (store side); afterwards the latched one (load side).
    assign steer_width  = (state == IDLE) ? req_width  : lat_width;
    assign steer_offset = (state == IDLE) ? req_offset : lat_offset;
    assign steer_signed = (state == IDLE) ? req_signed : lat_signed;

    lsu_lane_steer u_steer (
        .width      (steer_width),
        .offset     (steer_offset),
        .sign_ext   (steer_signed),
        .wdata      (req_wdata),
        .rdata_word (mem_data_in),
        .strobes    (steer_strobes),
        .store_data (steer_store),
        .load_data  (steer_load)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= IDLE;
            wait_count       <= 4'd0;
            lat_width        <= WIDTH_BYTE;
            lat_offset       <= 2'd0;
            lat_signed       <= 1'b0;
            lat_write        <= 1'b0;
            busy             <= 1'b0;
            ack              <= 1'b0;
            rdata            <= 32'd0;
            align_error      <= 1'b0;
            mem_address      <= 30'd0;
            mem_data_out     <= 32'd0;
            mem_data_strobes <= 4'd0;
            mem_read         <= 1'b0;
            mem_write        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack         <= 1'b0;
                    align_error <= 1'b0;
                    if (req) begin
                        lat_width  <= req_width;
                        lat_offset <= req_offset;
                        lat_signed <= req_signed;
                        lat_write  <= req_write;
                        busy       <= 1'b1;
                        if (reject) begin
                            align_error <= 1'b1;
                            state       <= DONE;
                        end else begin
                            mem_address      <= req_address[31:2];
                            mem_data_out     <= steer_store;
                            mem_data_strobes <= steer_strobes;
                            mem_read         <= !req_write;
                            mem_write        <= req_write;
                            wait_count       <= WAIT_LOAD;
                            state            <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // The memory has latched on the preceding falling edge, so read data is valid here.
                    if (wait_count == 4'd0) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (!lat_write)
                            rdata <= steer_load;
                        ack   <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_count <= wait_count - 4'd1;
                    end
                end
                DONE: begin
                    ack         <= 1'b0;
                    align_error <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: WAIT_CYCLES=0 and 3 instances, each with a falling-edge memory model.
module tb_load_store_unit;

    logic clock;
    logic reset_n;

    logic        req, req_write, req_signed;
    logic [1:0]  req_width;
    logic [31:0] req_address, req_wdata;
    logic        busy, ack, align_error, mem_read, mem_write;
    logic [31:0] rdata, mem_data_out, mem_data_in;
    logic [29:0] mem_address;
    logic [3:0]  mem_data_strobes;

    logic        req_w, req_write_w, req_signed_w;
    logic [1:0]  req_width_w;
    logic [31:0] req_address_w, req_wdata_w;
    logic        busy_w, ack_w, align_error_w, mem_read_w, mem_write_w;
    logic [31:0] rdata_w, mem_data_out_w, mem_data_in_w;
    logic [29:0] mem_address_w;
    logic [3:0]  mem_data_strobes_w;

    logic [31:0] mem0 [0:15];
    logic [31:0] mem3 [0:15];

    int passed = 0;
    int total  = 0;

    // Results of the last xfer on the WAIT_CYCLES=0 instance.
    int          r_cyc, r_rd, r_wr, r_extra, r_both;
    logic        r_ack, r_align, r_busy;
    logic [3:0]  r_strb;
    logic [31:0] r_dout;
    logic [29:0] r_addr;

    load_store_unit dut0 (
        .clock(clock), .reset_n(reset_n),
        .req(req), .req_write(req_write), .req_width(req_width), .req_signed(req_signed),
        .req_address(req_address), .req_wdata(req_wdata),
        .busy(busy), .ack(ack), .rdata(rdata), .align_error(align_error),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
        .mem_data_strobes(mem_data_strobes), .mem_read(mem_read), .mem_write(mem_write)
    );

    load_store_unit #(.WAIT_CYCLES(3)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .req(req_w), .req_write(req_write_w), .req_width(req_width_w), .req_signed(req_signed_w),
        .req_address(req_address_w), .req_wdata(req_wdata_w),
        .busy(busy_w), .ack(ack_w), .rdata(rdata_w), .align_error(align_error_w),
        .mem_address(mem_address_w), .mem_data_out(mem_data_out_w), .mem_data_in(mem_data_in_w),
        .mem_data_strobes(mem_data_strobes_w), .mem_read(mem_read_w), .mem_write(mem_write_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memories latch on the falling edge.
    always @(negedge clock) begin
        if (mem_read)
            mem_data_in <= mem0[mem_address[3:0]];
        if (mem_write)
            for (int b = 0; b < 4; b++)
                if (mem_data_strobes[b])
                    mem0[mem_address[3:0]][8*b +: 8] <= mem_data_out[8*b +: 8];
    end

    always @(negedge clock) begin
        if (mem_read_w)
            mem_data_in_w <= mem3[mem_address_w[3:0]];
        if (mem_write_w)
            for (int b = 0; b < 4; b++)
                if (mem_data_strobes_w[b])
                    mem3[mem_address_w[3:0]][8*b +: 8] <= mem_data_out_w[8*b +: 8];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample_enables();
        if (mem_read)  r_rd++;
        if (mem_write) r_wr++;
        if (mem_read && mem_write) r_both++;
    endtask

    task automatic xfer(input logic wr, input logic [1:0] w, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
        bit done, first;
        r_cyc = 0; r_rd = 0; r_wr = 0; r_extra = 0; r_both = 0;
        r_ack = 0; r_align = 0; r_busy = 0;
        r_strb = '0; r_dout = '0; r_addr = '0;
        req_write = wr; req_width = w; req_signed = sg; req_address = a; req_wdata = d;
        req = 1'b1;
        done = 0; first = 1;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            r_cyc++;
            sample_enables();
            if ((mem_read || mem_write) && first) begin
                first  = 0;
                r_strb = mem_data_strobes;
                r_dout = mem_data_out;
                r_addr = mem_address;
            end
            if (ack || align_error) begin
                r_ack   = ack;
                r_align = align_error;
                r_busy  = busy;
                done    = 1;
                req     = 1'b0;
            end
        end
        req = 1'b0;
        if (!done)
            check_val("xfer_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            sample_enables();
            if (ack || align_error || busy) r_extra++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 32'd0;
            mem3[i] = 32'd0;
        end
        mem3[4] = 32'hCAFEF00D;
        mem_data_in = 32'd0; mem_data_in_w = 32'd0;
        req = 0; req_write = 0; req_width = 0; req_signed = 0; req_address = 0; req_wdata = 0;
        req_w = 0; req_write_w = 0; req_width_w = 2'd2; req_signed_w = 0; req_address_w = 0; req_wdata_w = 0;
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();

        check_val("reset_ctrl", {26'd0, busy, ack, align_error, mem_read, mem_write, |mem_data_strobes}, 32'd0);
        check_val("reset_rdata", rdata, 32'd0);
        check_val("reset_addr_data", {2'b00, mem_address} | mem_data_out, 32'd0);

        // Word store then word load.
        xfer(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        check_val("st_word_ack_cyc", r_cyc, 2);
        check_val("st_word_ack", {31'd0, r_ack}, 1);
        check_val("st_word_busy_at_ack", {31'd0, r_busy}, 1);
        check_val("st_word_strobes", {28'd0, r_strb}, 32'hF);
        check_val("st_word_dout", r_dout, 32'hDEADBEEF);
        check_val("st_word_addr", {2'b00, r_addr}, 32'h4);
        check_val("st_word_wr_cnt", r_wr, 1);
        check_val("st_word_rd_cnt", r_rd, 0);
        check_val("st_word_tail", r_extra, 0);

        xfer(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check_val("ld_word_ack_cyc", r_cyc, 2);
        check_val("ld_word_rdata", rdata, 32'hDEADBEEF);
        check_val("ld_word_rd_cnt", r_rd, 1);
        check_val("ld_word_wr_cnt", r_wr, 0);

        // Byte store to offset 3 and signed/unsigned reload.
        xfer(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080);
        check_val("st_byte_strobes", {28'd0, r_strb}, 32'h1);
        check_val("st_byte_dout", r_dout, 32'h80808080);
        xfer(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        check_val("ld_byte_signed", rdata, 32'hFFFFFF80);
        xfer(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        check_val("ld_byte_unsigned", rdata, 32'h00000080);
        xfer(1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
        check_val("ld_byte_off0_signed", rdata, 32'hFFFFFFDE);

        // Half loads from 0x1234ABCD.
        xfer(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234ABCD);
        xfer(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        check_val("ld_half_signed", rdata, 32'hFFFFABCD);
        xfer(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        check_val("ld_half_unsigned", rdata, 32'h0000ABCD);
        xfer(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
        check_val("ld_half_upper", rdata, 32'h00001234);

        // Half store at offset 0, then width 3 behaves as word.
        xfer(1'b1, 2'd1, 1'b0, 32'h10, 32'h00005555);
        check_val("st_half_strobes", {28'd0, r_strb}, 32'hC);
        check_val("st_half_dout", r_dout, 32'h55555555);
        xfer(1'b0, 2'd3, 1'b1, 32'h10, 32'h0);
        check_val("ld_width3_rdata", rdata, 32'h5555ABCD);
        xfer(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        check_val("ld_byte_cd", rdata, 32'h000000CD);

        // Misaligned word load at 0x11.
        xfer(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
        check_val("unal_align_pulse", {31'd0, r_align}, 1);
        check_val("unal_cyc", r_cyc, 1);
        check_val("unal_no_ack", {31'd0, r_ack}, 0);
        check_val("unal_no_read", r_rd, 0);
        check_val("unal_rdata_kept", rdata, 32'h000000CD);
`else
        check_val("unal_ack", {31'd0, r_ack}, 1);
        check_val("unal_no_align", {31'd0, r_align}, 0);
        check_val("unal_addr", {2'b00, r_addr}, 32'h4);
        check_val("unal_rdata", rdata, 32'h5555ABCD);
`endif
        check_val("unal_tail", r_extra, 0);

        // Misaligned half store at 0x13.
        xfer(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000A5A5);
`ifdef LSU_ALIGN_CHECK_EN
        check_val("unal_half_align", {31'd0, r_align}, 1);
        check_val("unal_half_no_write", r_wr, 0);
`else
        check_val("unal_half_strobes", {28'd0, r_strb}, 32'h3);
        check_val("unal_half_dout", r_dout, 32'hA5A5A5A5);
`endif

        // WAIT_CYCLES=3 instance: word load with req pulses while busy.
        begin
            int cyc3, rd3, bad_addr, extra3;
            bit done3;
            cyc3 = 0; rd3 = 0; bad_addr = 0; extra3 = 0; done3 = 0;
            req_address_w = 32'h10; req_w = 1'b1;
            for (int i = 0; i < 20 && !done3; i++) begin
                tick();
                cyc3++;
                if (mem_read_w) begin
                    rd3++;
                    if (mem_address_w !== 30'h4) bad_addr++;
                end
                if (ack_w) begin
                    done3 = 1;
                    req_w = 1'b0;
                end else begin
                    req_w = cyc3[0];
                    req_address_w = 32'h20;
                end
            end
            req_w = 1'b0;
            if (!done3)
                check_val("w3_timeout", 32'd0, 32'd1);
            for (int i = 0; i < 4; i++) begin
                tick();
                if (mem_read_w) rd3++;
                if (ack_w) extra3++;
            end
            check_val("w3_ack_cyc", cyc3, 5);
            check_val("w3_read_cycles", rd3, 4);
            check_val("w3_addr_stable", bad_addr, 0);
            check_val("w3_rdata", rdata_w, 32'hCAFEF00D);
            check_val("w3_no_extra_ack", extra3, 0);
        end

        // Reset during store ACCESS.
        req_write = 1'b1; req_width = 2'd2; req_signed = 1'b0; req_address = 32'h14; req_wdata = 32'hFFFFFFFF;
        req = 1'b1;
        tick();
        check_val("rst_mid_write_on", {31'd0, mem_write}, 1);
        reset_n = 1'b0;
        req = 1'b0;
        tick();
        check_val("rst_mid_ctrl", {26'd0, busy, ack, align_error, mem_read, mem_write, |mem_data_strobes}, 32'd0);
        check_val("rst_mid_addr", {2'b00, mem_address}, 32'd0);
        check_val("rst_mid_dout", mem_data_out, 32'd0);
        check_val("rst_mid_rdata", rdata, 32'd0);
        reset_n = 1'b1;
        begin
            int acks;
            acks = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (ack || mem_write || busy) acks++;
            end
            check_val("rst_mid_no_ack", acks, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
